// File: rtl/panda_pkg.sv
// rtl/panda_pkg.sv - shared types and decode helpers for the panda multiply/divide unit
package panda_pkg;

    typedef enum logic [1:0] {
        MD_DIV,
        MD_DIVU,
        MD_REM,
        MD_REMU
    } md_operator_e;

    typedef enum logic [1:0] {
        MD_IDLE,
        MD_CALC,
        MD_DONE
    } md_state_e;

    function automatic logic is_signed_op(input md_operator_e op);
        return (op == MD_DIV) || (op == MD_REM);
    endfunction

    // Anything that is not a remainder op yields the quotient, so unknown codes act as DIVU.
    function automatic logic is_rem_op(input md_operator_e op);
        return (op == MD_REM) || (op == MD_REMU);
    endfunction

endpackage

// File: rtl/panda_adder.sv
// rtl/panda_adder.sv - combinational add/subtract shared by the ALU and divider
module panda_adder #(
    parameter int Width = 32
) (
    input  logic [Width-1:0] operand_a_i,
    input  logic [Width-1:0] operand_b_i,
    input  logic             subtract_i,
    output logic [Width-1:0] result_o
);

    logic [Width-1:0] b_eff;
    logic [Width-1:0] carry_in;

    assign b_eff    = subtract_i ? ~operand_b_i : operand_b_i;
    assign carry_in = {{(Width-1){1'b0}}, subtract_i};
    assign result_o = operand_a_i + b_eff + carry_in;

endmodule

// File: rtl/panda_divider.sv
// rtl/panda_divider.sv - iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU
module panda_divider
    import panda_pkg::*;
#(
    parameter int Width = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  md_operator_e     operator_i,
    input  logic [Width-1:0] operand_a_i,
    input  logic [Width-1:0] operand_b_i,
    input  logic             kill_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [Width-1:0] result_o
);

    localparam int CntW = $clog2(Width);

    md_state_e        state_q, state_d;
    md_operator_e     op_q;
    logic [CntW-1:0]  cnt_q;
    logic [Width-1:0] rem_q, quo_q, abs_b_q, result_q;
    logic             sign_a_q, sign_b_q;

    logic             accept, signed_op, sign_a, sign_b, div_zero, ovf;
    logic [Width-1:0] abs_a, abs_b, early_result;

    assign ready_o  = (state_q == MD_IDLE);
    assign valid_o  = (state_q == MD_DONE);
    assign result_o = result_q;
    assign accept   = valid_i & ready_o & ~kill_i;

    assign signed_op = is_signed_op(operator_i);
    assign sign_a    = signed_op & operand_a_i[Width-1];
    assign sign_b    = signed_op & operand_b_i[Width-1];
    assign abs_a     = sign_a ? -operand_a_i : operand_a_i;
    assign abs_b     = sign_b ? -operand_b_i : operand_b_i;
    assign div_zero  = (operand_b_i == '0);
    assign ovf       = signed_op && (operand_a_i == {1'b1, {(Width-1){1'b0}}})
                       && (operand_b_i == '1);

    // Division by zero and signed overflow bypass the iteration entirely.
    always_comb begin
        early_result = '0;
        if (div_zero) begin
            early_result = is_rem_op(operator_i) ? operand_a_i : '1;
        end else if (ovf) begin
            early_result = is_rem_op(operator_i) ? '0 : operand_a_i;
        end
    end

    logic [Width:0]   rem_shifted, trial;
    logic [Width-1:0] rem_step, quo_step, final_result;

    assign rem_shifted = {rem_q, quo_q[Width-1]};

    panda_adder #(
        .Width(Width + 1)
    ) u_trial_sub (
        .operand_a_i(rem_shifted),
        .operand_b_i({1'b0, abs_b_q}),
        .subtract_i (1'b1),
        .result_o   (trial)
    );

    assign rem_step = trial[Width] ? rem_shifted[Width-1:0] : trial[Width-1:0];
    assign quo_step = {quo_q[Width-2:0], ~trial[Width]};

    always_comb begin
        if (is_rem_op(op_q)) begin
            final_result = sign_a_q ? -rem_step : rem_step;
        end else begin
            final_result = (sign_a_q ^ sign_b_q) ? -quo_step : quo_step;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= MD_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            MD_IDLE: if (accept) state_d = (div_zero || ovf) ? MD_DONE : MD_CALC;
            MD_CALC: if (cnt_q == '0) state_d = MD_DONE;
            MD_DONE: if (ready_i) state_d = MD_IDLE;
            default: state_d = MD_IDLE;
        endcase
        if (kill_i) begin
            state_d = MD_IDLE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            op_q     <= MD_DIVU;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            abs_b_q  <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            result_q <= '0;
        end else if (accept) begin
            op_q     <= operator_i;
            cnt_q    <= CntW'(Width - 1);
            rem_q    <= '0;
            quo_q    <= abs_a;
            abs_b_q  <= abs_b;
            sign_a_q <= sign_a;
            sign_b_q <= sign_b;
            if (div_zero || ovf) begin
                result_q <= early_result;
            end
        end else if (state_q == MD_CALC && !kill_i) begin
            rem_q <= rem_step;
            quo_q <= quo_step;
            cnt_q <= cnt_q - CntW'(1);
            if (cnt_q == '0) begin
                result_q <= final_result;
            end
        end
    end

endmodule

// File: tb/tb_panda_divider.sv
// tb/tb_panda_divider.sv - directed vector bench for panda_divider
module tb_panda_divider;
    import panda_pkg::*;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         valid_i = 1'b0;
    logic         ready_o;
    md_operator_e operator_i = MD_DIVU;
    logic [31:0]  operand_a_i = '0;
    logic [31:0]  operand_b_i = '0;
    logic         kill_i = 1'b0;
    logic         valid_o;
    logic         ready_i = 1'b0;
    logic [31:0]  result_o;

    int total = 0;
    int bad   = 0;

    panda_divider #(.Width(32)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .operator_i (operator_i),
        .operand_a_i(operand_a_i),
        .operand_b_i(operand_b_i),
        .kill_i     (kill_i),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .result_o   (result_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        md_operator_e op;
        logic [31:0]  a;
        logic [31:0]  b;
        logic [31:0]  exp;
        int           lat;
    } vec_t;

    vec_t vecs[16];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Presents one request, counting edges from the accepting edge until valid_o is seen.
    task automatic run_op(input md_operator_e op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat);
        operator_i  = op;
        operand_a_i = a;
        operand_b_i = b;
        valid_i     = 1'b1;
        lat         = -1;
        res         = 'x;
        for (int c = 1; c <= 100; c++) begin
            tick();
            valid_i = 1'b0;
            if (valid_o) begin
                lat = c;
                res = result_o;
                break;
            end
        end
    endtask

    task automatic handshake();
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
    endtask

    task automatic wait_quiet(input string name, input int cycles);
        logic seen = 1'b0;
        for (int c = 0; c < cycles; c++) begin
            tick();
            if (valid_o) seen = 1'b1;
        end
        check(name, {31'd0, seen}, 32'd0);
    endtask

    logic [31:0] res;
    int          lat;

    initial begin
        vecs[0]  = '{MD_DIV,  32'd20,        32'hFFFFFFFD, 32'hFFFFFFFA, 33};
        vecs[1]  = '{MD_REM,  32'd20,        32'hFFFFFFFD, 32'h00000002, 33};
        vecs[2]  = '{MD_REM,  32'hFFFFFFF9,  32'd2,        32'hFFFFFFFF, 33};
        vecs[3]  = '{MD_DIVU, 32'hFFFFFFFF,  32'd1,        32'hFFFFFFFF, 33};
        vecs[4]  = '{MD_REMU, 32'd100,       32'd7,        32'd2,        33};
        vecs[5]  = '{MD_DIVU, 32'd7,         32'd0,        32'hFFFFFFFF, 1};
        vecs[6]  = '{MD_REMU, 32'd7,         32'd0,        32'd7,        1};
        vecs[7]  = '{MD_DIV,  32'hFFFFFFFB,  32'd0,        32'hFFFFFFFF, 1};
        vecs[8]  = '{MD_REM,  32'hFFFFFFFB,  32'd0,        32'hFFFFFFFB, 1};
        vecs[9]  = '{MD_DIV,  32'h80000000,  32'hFFFFFFFF, 32'h80000000, 1};
        vecs[10] = '{MD_REM,  32'h80000000,  32'hFFFFFFFF, 32'h00000000, 1};
        vecs[11] = '{MD_DIV,  32'hFFFFFFEC,  32'hFFFFFFFD, 32'd6,        33};
        vecs[12] = '{MD_DIVU, 32'd9,         32'd3,        32'd3,        33};
        vecs[13] = '{MD_REMU, 32'd5,         32'd9,        32'd5,        33};
        vecs[14] = '{MD_DIV,  32'h80000000,  32'd1,        32'h80000000, 33};
        vecs[15] = '{MD_REM,  32'h80000000,  32'd3,        32'hFFFFFFFE, 33};

        tick();
        tick();
        rst = 1'b0;
        check("reset_ready", {31'd0, ready_o}, 32'd1);
        check("reset_valid", {31'd0, valid_o}, 32'd0);
        check("reset_result", result_o, 32'd0);

        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, lat);
            check($sformatf("vec%0d_result", i), res, vecs[i].exp);
            check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
            handshake();
            check($sformatf("vec%0d_ready_after", i), {31'd0, ready_o}, 32'd1);
        end

        // Backpressure: hold result while a new request stays pending.
        run_op(MD_DIVU, 32'd100, 32'd7, res, lat);
        check("bp_first", res, 32'd14);
        operator_i  = MD_DIVU;
        operand_a_i = 32'd50;
        operand_b_i = 32'd5;
        valid_i     = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            check("bp_valid_held", {31'd0, valid_o}, 32'd1);
            check("bp_result_held", result_o, 32'd14);
            check("bp_not_ready", {31'd0, ready_o}, 32'd0);
        end
        ready_i = 1'b1;
        tick();
        valid_i = 1'b0;
        ready_i = 1'b0;
        check("bp_ready_rise", {31'd0, ready_o}, 32'd1);
        check("bp_valid_drop", {31'd0, valid_o}, 32'd0);

        // Kill ten cycles into the iteration.
        operator_i  = MD_DIV;
        operand_a_i = 32'd20;
        operand_b_i = 32'hFFFFFFFD;
        valid_i     = 1'b1;
        tick();
        valid_i = 1'b0;
        check("kill_busy", {31'd0, ready_o}, 32'd0);
        for (int c = 0; c < 9; c++) tick();
        kill_i = 1'b1;
        valid_i = 1'b1;
        tick();
        kill_i = 1'b0;
        valid_i = 1'b0;
        check("kill_ready", {31'd0, ready_o}, 32'd1);
        wait_quiet("kill_no_valid", 40);
        run_op(MD_DIVU, 32'd9, 32'd3, res, lat);
        check("kill_next_result", res, 32'd3);
        check("kill_next_latency", lat, 33);
        handshake();

        // Reset in the middle of an iteration.
        operator_i  = MD_DIVU;
        operand_a_i = 32'd1000;
        operand_b_i = 32'd7;
        valid_i     = 1'b1;
        tick();
        valid_i = 1'b0;
        for (int c = 0; c < 9; c++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_ready", {31'd0, ready_o}, 32'd1);
        check("rst_result", result_o, 32'd0);
        wait_quiet("rst_no_valid", 40);
        run_op(MD_DIVU, 32'd9, 32'd3, res, lat);
        check("rst_next_result", res, 32'd3);
        check("rst_next_latency", lat, 33);
        handshake();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
